// File: rtl/spatz_pkg.sv
// Shared types for the SIMD operand collector: element descriptor, operation
// and element-width enums, and the bit positions inside the need mask.
package spatz_pkg;

  typedef enum logic [3:0] {
    VADD, VSUB, VMUL, VMACC, VAND, VOR, VXOR, VSLL, VSRL, VMIN, VMAX
  } op_e;

  typedef enum logic [1:0] {
    EW_8, EW_16, EW_32, EW_64
  } vew_e;

  localparam int unsigned NeedS1 = 0;
  localparam int unsigned NeedS2 = 1;
  localparam int unsigned NeedD  = 2;

  typedef struct packed {
    op_e        op;
    vew_e       sew;
    logic       is_signed;
    logic       carry;
    logic [2:0] need;  // {d, s2, s1}
    logic       last;
  } simd_req_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through: when empty, a push is
// visible on data_o in the same cycle and can be popped without being stored.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrDepth:0]   FullCnt = (AddrDepth+1)'(DEPTH);
  localparam logic [AddrDepth:0]   CntOne  = (AddrDepth+1)'(1);
  localparam logic [AddrDepth-1:0] LastPtr = AddrDepth'(DEPTH - 1);
  localparam logic [AddrDepth-1:0] PtrOne  = AddrDepth'(1);

  dtype                 mem_q [DEPTH];
  logic [AddrDepth-1:0] rd_ptr_q, wr_ptr_q;
  logic [AddrDepth:0]   cnt_q;
  logic                 push_ok, pop_ok, bypass;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  // Pushed and popped in the same cycle while empty: the entry never lands.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_ok && pop_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (!bypass) begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + CntOne;
      end else if (!push_ok && pop_ok) begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

endmodule

// File: rtl/spatz_simd_operand_collector.sv
// Aligns independently arriving s1/s2/d operands with their element descriptor
// and issues one registered, complete operand set per cycle to the SIMD lanes.
module spatz_simd_operand_collector
  import spatz_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  simd_req_t        req_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [Width-1:0] s1_i,
  input  logic [Width-1:0] s2_i,
  input  logic [Width-1:0] d_i,
  input  logic             s1_valid_i,
  input  logic             s2_valid_i,
  input  logic             d_valid_i,
  output logic             s1_ready_o,
  output logic             s2_ready_o,
  output logic             d_ready_o,
  output logic [Width-1:0] op_s1_o,
  output logic [Width-1:0] op_s2_o,
  output logic [Width-1:0] op_d_o,
  output op_e              operation_o,
  output vew_e             sew_o,
  output logic             is_signed_o,
  output logic             carry_o,
  output logic             last_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      issued_cnt_o
);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high. Input readies are !full only (never from ready_i);
  // valid_o and all issued fields hold stable until ready_i is seen.
  typedef enum logic {OutEmpty, OutFull} out_state_e;
  out_state_e out_state;

  simd_req_t        req_head;
  logic [Width-1:0] s1_head, s2_head, d_head;
  logic req_empty, s1_empty, s2_empty, d_empty;
  logic req_full, s1_full, s2_full, d_full;
  logic ops_avail, slot_free, fire;

  assign req_ready_o = !req_full;
  assign s1_ready_o  = !s1_full;
  assign s2_ready_o  = !s2_full;
  assign d_ready_o   = !d_full;

  fifo_v3 #(
    .FALL_THROUGH(1'b1), .DATA_WIDTH($bits(simd_req_t)), .DEPTH(Depth), .dtype(simd_req_t)
  ) i_req_fifo (
    .clk_i, .rst_ni, .flush_i,
    .full_o(req_full), .empty_o(req_empty),
    .data_i(req_i), .push_i(req_valid_i && req_ready_o),
    .data_o(req_head), .pop_i(fire)
  );

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(Width), .DEPTH(Depth)) i_s1_fifo (
    .clk_i, .rst_ni, .flush_i,
    .full_o(s1_full), .empty_o(s1_empty),
    .data_i(s1_i), .push_i(s1_valid_i && s1_ready_o),
    .data_o(s1_head), .pop_i(fire && req_head.need[NeedS1])
  );

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(Width), .DEPTH(Depth)) i_s2_fifo (
    .clk_i, .rst_ni, .flush_i,
    .full_o(s2_full), .empty_o(s2_empty),
    .data_i(s2_i), .push_i(s2_valid_i && s2_ready_o),
    .data_o(s2_head), .pop_i(fire && req_head.need[NeedS2])
  );

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(Width), .DEPTH(Depth)) i_d_fifo (
    .clk_i, .rst_ni, .flush_i,
    .full_o(d_full), .empty_o(d_empty),
    .data_i(d_i), .push_i(d_valid_i && d_ready_o),
    .data_o(d_head), .pop_i(fire && req_head.need[NeedD])
  );

  // Operand FIFOs outside the head's need mask are neither waited on nor popped.
  assign ops_avail = (!req_head.need[NeedS1] || !s1_empty)
                  && (!req_head.need[NeedS2] || !s2_empty)
                  && (!req_head.need[NeedD]  || !d_empty);
  assign slot_free = (out_state == OutEmpty) || ready_i;
  assign fire      = !req_empty && ops_avail && slot_free && !flush_i;

  assign valid_o = (out_state == OutFull);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_state    <= OutEmpty;
      op_s1_o      <= '0;
      op_s2_o      <= '0;
      op_d_o       <= '0;
      operation_o  <= VADD;
      sew_o        <= EW_8;
      is_signed_o  <= 1'b0;
      carry_o      <= 1'b0;
      last_o       <= 1'b0;
      issued_cnt_o <= '0;
    end else if (flush_i) begin
      out_state    <= OutEmpty;
      issued_cnt_o <= '0;
    end else begin
      unique case (out_state)
        OutEmpty: if (fire) out_state <= OutFull;
        OutFull:  if (ready_i && !fire) out_state <= OutEmpty;
        default:  out_state <= OutEmpty;
      endcase
      if (fire) begin
        op_s1_o      <= req_head.need[NeedS1] ? s1_head : '0;
        op_s2_o      <= req_head.need[NeedS2] ? s2_head : '0;
        op_d_o       <= req_head.need[NeedD]  ? d_head  : '0;
        operation_o  <= req_head.op;
        sew_o        <= req_head.sew;
        is_signed_o  <= req_head.is_signed;
        carry_o      <= req_head.carry;
        last_o       <= req_head.last;
        issued_cnt_o <= issued_cnt_o + 32'd1;
      end
    end
  end

endmodule
